// File: rtl/udp_video_rx.sv
// udp_video_rx: GMII receive parser for video carried over UDP.
// Strips preamble/SFD and the Ethernet, IPv4 and UDP headers. Packets are
// filtered on destination MAC and IP. The payload is packed MSB-first into
// PIX_BYTES-wide pixel words, and a leading SYNC_WORD is flagged on vs.
// Optional feature macro: UDP_PORT_FILTER_EN. When it is defined, only packets
// whose UDP destination port equals BOARD_PORT are accepted.
module udp_video_rx #(
    parameter logic [47:0] BOARD_MAC    = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP     = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [15:0] BOARD_PORT   = 16'd1234,
    parameter int          PIX_BYTES    = 3,
    parameter logic [31:0] SYNC_WORD    = 32'hF0_5A_A5_0F,
    parameter bit          ACCEPT_BCAST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   gmii_rx_dv,
    input  logic [7:0]             gmii_rxd,
    output logic                   rec_en,
    output logic [8*PIX_BYTES-1:0] rec_data,
    output logic                   vs,
    output logic                   rec_pkt_done,
    output logic [15:0]            rec_byte_num,
    output logic                   pkt_err
);

    localparam int         W  = 8 * PIX_BYTES;
    localparam logic [2:0] PB = 3'(PIX_BYTES);

`ifdef UDP_PORT_FILTER_EN
    localparam bit PORT_FILTER = 1'b1;
`else
    localparam bit PORT_FILTER = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        ETH_HDR,
        IP_HDR,
        UDP_HDR,
        PAYLOAD,
        DISCARD
    } state_t;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;          // byte index inside the current header
    logic [3:0]  ihl_reg, ihl_next;
    logic        mac_uni_reg, mac_uni_next;  // dest MAC still matches BOARD_MAC
    logic        mac_bc_reg, mac_bc_next;    // dest MAC still matches broadcast
    logic [7:0]  len_hi_reg, len_hi_next;
    logic [15:0] pay_len_reg, pay_len_next;
    logic [15:0] pay_cnt_reg, pay_cnt_next;

    // Control strobes from the parser to the packing datapath
    logic        pay_byte;    // a payload byte is being sampled
    logic        pay_last;    // it is the final payload byte
    logic        abort;       // dv dropped mid-payload
    logic        empty_done;  // UDP length == 8: packet done with no payload

    logic [7:0]  mac_byte;
    logic [7:0]  ip_byte;
    logic        mac_uni_ok, mac_bc_ok;

    // Header byte of the board address that corresponds to the current index
    assign mac_byte = 8'(BOARD_MAC >> {3'd5 - cnt_reg[2:0], 3'b000});
    assign ip_byte  = 8'(BOARD_IP >> {2'd3 - cnt_reg[1:0], 3'b000});

    // Parser state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            ihl_reg     <= '0;
            mac_uni_reg <= 1'b0;
            mac_bc_reg  <= 1'b0;
            len_hi_reg  <= '0;
            pay_len_reg <= '0;
            pay_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            ihl_reg     <= ihl_next;
            mac_uni_reg <= mac_uni_next;
            mac_bc_reg  <= mac_bc_next;
            len_hi_reg  <= len_hi_next;
            pay_len_reg <= pay_len_next;
            pay_cnt_reg <= pay_cnt_next;
        end
    end

    // Parser next-state logic: header checks and payload framing
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        ihl_next     = ihl_reg;
        mac_uni_next = mac_uni_reg;
        mac_bc_next  = mac_bc_reg;
        len_hi_next  = len_hi_reg;
        pay_len_next = pay_len_reg;
        pay_cnt_next = pay_cnt_reg;
        pay_byte     = 1'b0;
        pay_last     = 1'b0;
        abort        = 1'b0;
        empty_done   = 1'b0;
        mac_uni_ok   = 1'b0;
        mac_bc_ok    = 1'b0;

        if (!gmii_rx_dv) begin
            state_next = IDLE;
            if (state_reg == PAYLOAD) begin
                abort = 1'b1;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (gmii_rxd == 8'h55) begin
                        state_next = PREAMBLE;
                        cnt_next   = 6'd1;
                    end
                end

                PREAMBLE: begin
                    if (gmii_rxd == 8'h55 && cnt_reg < 6'd7) begin
                        cnt_next = cnt_reg + 6'd1;
                    end else if (gmii_rxd == 8'hD5 && cnt_reg == 6'd7) begin
                        state_next   = ETH_HDR;
                        cnt_next     = '0;
                        mac_uni_next = 1'b1;
                        mac_bc_next  = ACCEPT_BCAST;
                    end else begin
                        state_next = DISCARD;
                    end
                end

                ETH_HDR: begin
                    cnt_next = cnt_reg + 6'd1;
                    if (cnt_reg < 6'd6) begin
                        mac_uni_ok   = mac_uni_reg && (gmii_rxd == mac_byte);
                        mac_bc_ok    = mac_bc_reg && (gmii_rxd == 8'hFF);
                        mac_uni_next = mac_uni_ok;
                        mac_bc_next  = mac_bc_ok;
                        if (cnt_reg == 6'd5 && !mac_uni_ok && !mac_bc_ok) begin
                            state_next = DISCARD;
                        end
                    end else if (cnt_reg == 6'd12) begin
                        if (gmii_rxd != 8'h08) begin
                            state_next = DISCARD;
                        end
                    end else if (cnt_reg == 6'd13) begin
                        if (gmii_rxd != 8'h00) begin
                            state_next = DISCARD;
                        end else begin
                            state_next = IP_HDR;
                            cnt_next   = '0;
                        end
                    end
                end

                IP_HDR: begin
                    cnt_next = cnt_reg + 6'd1;
                    // End of header including options; the checks below override it
                    if (cnt_reg != 6'd0 && cnt_reg == 6'({ihl_reg, 2'b00} - 6'd1)) begin
                        state_next = UDP_HDR;
                        cnt_next   = '0;
                    end
                    if (cnt_reg == 6'd0) begin
                        ihl_next = gmii_rxd[3:0];
                        if (gmii_rxd[7:4] != 4'd4 || gmii_rxd[3:0] < 4'd5) begin
                            state_next = DISCARD;
                        end
                    end else if (cnt_reg == 6'd9) begin
                        if (gmii_rxd != 8'd17) begin
                            state_next = DISCARD;
                        end
                    end else if (cnt_reg >= 6'd16 && cnt_reg <= 6'd19) begin
                        if (gmii_rxd != ip_byte) begin
                            state_next = DISCARD;
                        end
                    end
                end

                UDP_HDR: begin
                    cnt_next = cnt_reg + 6'd1;
                    case (cnt_reg)
                        6'd2: begin
                            if (PORT_FILTER && gmii_rxd != BOARD_PORT[15:8]) begin
                                state_next = DISCARD;
                            end
                        end
                        6'd3: begin
                            if (PORT_FILTER && gmii_rxd != BOARD_PORT[7:0]) begin
                                state_next = DISCARD;
                            end
                        end
                        6'd4: len_hi_next = gmii_rxd;
                        6'd5: begin
                            if ({len_hi_reg, gmii_rxd} < 16'd8) begin
                                state_next = DISCARD;
                            end
                            pay_len_next = {len_hi_reg, gmii_rxd} - 16'd8;
                        end
                        6'd7: begin
                            pay_cnt_next = '0;
                            if (pay_len_reg == 16'd0) begin
                                empty_done = 1'b1;
                                state_next = DISCARD;
                            end else begin
                                state_next = PAYLOAD;
                            end
                        end
                        default: ;
                    endcase
                end

                PAYLOAD: begin
                    pay_byte     = 1'b1;
                    pay_cnt_next = pay_cnt_reg + 16'd1;
                    if (pay_cnt_reg == pay_len_reg - 16'd1) begin
                        pay_last   = 1'b1;
                        state_next = DISCARD;  // padding and FCS are dropped
                    end
                end

                DISCARD: ;

                default: state_next = IDLE;
            endcase
        end
    end

    // Packing datapath: a 4-byte MSB-aligned byte queue. Bytes past q_cnt_reg are
    // always zero, so a short final pixel comes out zero-filled without extra masking.
    logic [31:0] q_reg, q_next, q_in;
    logic [2:0]  q_cnt_reg, q_cnt_next, cnt_in, take;
    logic        drain_reg, drain_next;
    logic        hold, flush, sync_hit, emit, done, vs_set;

    logic          rec_en_reg;
    logic [W-1:0]  rec_data_reg;
    logic          vs_reg, done_reg, err_reg;
    logic [15:0]   byte_num_reg;

    // Next queue contents, pixel emission, sync detect and completion
    always_comb begin
        q_in       = q_reg;
        cnt_in     = q_cnt_reg;
        q_next     = q_reg;
        q_cnt_next = q_cnt_reg;
        drain_next = 1'b0;
        emit       = 1'b0;
        done       = 1'b0;
        vs_set     = 1'b0;
        take       = PB;

        if (pay_byte) begin
            q_in   = q_reg | ({gmii_rxd, 24'd0} >> {q_cnt_reg, 3'b000});
            cnt_in = q_cnt_reg + 3'd1;
        end

        // The first four bytes wait until the sync compare has resolved
        hold     = pay_byte && (pay_len_reg >= 16'd4) && (pay_cnt_reg < 16'd3);
        sync_hit = pay_byte && (pay_len_reg >= 16'd4) && (pay_cnt_reg == 16'd3)
                   && (q_in == SYNC_WORD);
        flush    = pay_last || drain_reg;

        if (flush && cnt_in < PB) begin
            take = cnt_in;
        end

        q_next     = q_in;
        q_cnt_next = cnt_in;

        if (abort) begin
            q_next     = '0;
            q_cnt_next = '0;
        end else if (sync_hit) begin
            vs_set     = 1'b1;
            q_next     = '0;
            q_cnt_next = '0;
            done       = pay_last;
        end else if (!hold) begin
            if (cnt_in != 3'd0 && (flush || cnt_in >= PB)) begin
                emit       = 1'b1;
                q_next     = q_in << {take, 3'b000};
                q_cnt_next = cnt_in - take;
            end
            // Completion waits until the last queued byte has left
            if (flush) begin
                if (q_cnt_next == 3'd0) begin
                    done = 1'b1;
                end else begin
                    drain_next = 1'b1;
                end
            end
        end

        if (empty_done) begin
            done = 1'b1;
        end
    end

    // Queue and output registers; every strobe is a registered single-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg        <= '0;
            q_cnt_reg    <= '0;
            drain_reg    <= 1'b0;
            rec_en_reg   <= 1'b0;
            rec_data_reg <= '0;
            vs_reg       <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            byte_num_reg <= '0;
        end else begin
            q_reg      <= q_next;
            q_cnt_reg  <= q_cnt_next;
            drain_reg  <= drain_next;
            rec_en_reg <= emit;
            vs_reg     <= vs_set;
            done_reg   <= done;
            err_reg    <= abort;
            if (emit) begin
                rec_data_reg <= q_in[31 -: W];
            end
            if (done) begin
                byte_num_reg <= pay_len_reg;
            end
        end
    end

    assign rec_en       = rec_en_reg;
    assign rec_data     = rec_data_reg;
    assign vs           = vs_reg;
    assign rec_pkt_done = done_reg;
    assign rec_byte_num = byte_num_reg;
    assign pkt_err      = err_reg;

endmodule

// File: tb/tb_udp_video_rx.sv
// tb_udp_video_rx: directed packets into udp_video_rx with hand-computed
// expected pixel words, strobe counts and payload lengths.
module tb_udp_video_rx;

    localparam logic [47:0] MAC_OK = 48'h00_11_22_33_44_55;
    localparam logic [31:0] IP_OK  = {8'd192, 8'd168, 8'd1, 8'd10};

    logic        clk = 1'b0;
    logic        rst;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        rec_en;
    logic [23:0] rec_data;
    logic        vs;
    logic        rec_pkt_done;
    logic [15:0] rec_byte_num;
    logic        pkt_err;

    int check_cnt = 0;
    int err_cnt   = 0;

    // Monitor state
    logic [31:0] en_data[$];
    int          vs_cnt, done_cnt, perr_cnt, done_with_en;
    logic [15:0] last_num;

    logic [7:0]  pl[$];
    logic [7:0]  pkt[$];

    udp_video_rx #(
        .BOARD_MAC    (MAC_OK),
        .BOARD_IP     (IP_OK),
        .BOARD_PORT   (16'd1234),
        .PIX_BYTES    (3),
        .SYNC_WORD    (32'hF0_5A_A5_0F),
        .ACCEPT_BCAST (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rxd     (gmii_rxd),
        .rec_en       (rec_en),
        .rec_data     (rec_data),
        .vs           (vs),
        .rec_pkt_done (rec_pkt_done),
        .rec_byte_num (rec_byte_num),
        .pkt_err      (pkt_err)
    );

    always #4 clk = ~clk;

    // Record every output strobe away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (rec_en) en_data.push_back(32'(rec_data));
            if (vs) vs_cnt++;
            if (pkt_err) perr_cnt++;
            if (rec_pkt_done) begin
                done_cnt++;
                last_num = rec_byte_num;
                if (rec_en) done_with_en++;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [31:0] pix(input int i);
        return (en_data.size() > i) ? en_data[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_mon();
        en_data.delete();
        vs_cnt = 0;
        done_cnt = 0;
        perr_cnt = 0;
        done_with_en = 0;
        last_num = 16'hFFFF;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_seq(input int start, input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'(start + i));
    endtask

    // Ethernet/IPv4/UDP frame around the payload in pl, with a dummy FCS
    task automatic build(input logic [47:0] mac, input logic [31:0] ip, input logic [7:0] proto,
                         input logic [15:0] port, input int npre);
        logic [15:0] tl, ul;
        tl = 16'(28 + pl.size());
        ul = 16'(8 + pl.size());
        pkt.delete();
        repeat (npre) pkt.push_back(8'h55);
        pkt.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) pkt.push_back(mac[8*i +: 8]);
        pkt.push_back(8'h02); repeat (4) pkt.push_back(8'h00); pkt.push_back(8'h01);
        pkt.push_back(8'h08); pkt.push_back(8'h00);
        pkt.push_back(8'h45); pkt.push_back(8'h00); pkt.push_back(tl[15:8]); pkt.push_back(tl[7:0]);
        pkt.push_back(8'h00); pkt.push_back(8'h00); pkt.push_back(8'h40); pkt.push_back(8'h00);
        pkt.push_back(8'h40); pkt.push_back(proto); pkt.push_back(8'h00); pkt.push_back(8'h00);
        pkt.push_back(8'hC0); pkt.push_back(8'hA8); pkt.push_back(8'h01); pkt.push_back(8'h02);
        for (int i = 3; i >= 0; i--) pkt.push_back(ip[8*i +: 8]);
        pkt.push_back(8'h04); pkt.push_back(8'h00); pkt.push_back(port[15:8]); pkt.push_back(port[7:0]);
        pkt.push_back(ul[15:8]); pkt.push_back(ul[7:0]); pkt.push_back(8'h00); pkt.push_back(8'h00);
        foreach (pl[i]) pkt.push_back(pl[i]);
        pkt.push_back(8'hDE); pkt.push_back(8'hAD); pkt.push_back(8'hBE); pkt.push_back(8'hEF);
    endtask

    // Drive the frame (or only its first 'cut' bytes), then one dv-low cycle or a reset
    task automatic send(input int cut, input bit rst_cut);
        int n;
        n = (cut < 0) ? pkt.size() : cut;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            gmii_rx_dv = 1'b1;
            gmii_rxd   = pkt[i];
        end
        @(posedge clk); #1;
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        if (rst_cut) begin
            rst = 1'b1;
            #1;
            check_val("midrst_rec_en", 32'(rec_en), 0);
            check_val("midrst_rec_data", 32'(rec_data), 0);
            check_val("midrst_vs", 32'(vs), 0);
            check_val("midrst_done", 32'(rec_pkt_done), 0);
            check_val("midrst_byte_num", 32'(rec_byte_num), 0);
            check_val("midrst_pkt_err", 32'(pkt_err), 0);
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    function automatic int strobes();
        return en_data.size() + vs_cnt + done_cnt + perr_cnt;
    endfunction

    initial begin
        rst = 1'b1;
        gmii_rx_dv = 1'b0;
        gmii_rxd = 8'h00;
        clear_mon();
        idle(3);
        check_val("reset_rec_en", 32'(rec_en), 0);
        check_val("reset_rec_data", 32'(rec_data), 0);
        check_val("reset_vs", 32'(vs), 0);
        check_val("reset_done", 32'(rec_pkt_done), 0);
        check_val("reset_byte_num", 32'(rec_byte_num), 0);
        check_val("reset_pkt_err", 32'(pkt_err), 0);
        rst = 1'b0;
        idle(2);

        // Nine-byte payload: three full pixels
        clear_mon(); set_seq(0, 9); build(MAC_OK, IP_OK, 8'd17, 16'd1234, 7); send(-1, 0); idle(8);
        check_val("p9_en_count", en_data.size(), 3);
        check_val("p9_pix0", pix(0), 32'h000102);
        check_val("p9_pix1", pix(1), 32'h030405);
        check_val("p9_pix2", pix(2), 32'h060708);
        check_val("p9_done", done_cnt, 1);
        check_val("p9_byte_num", 32'(last_num), 9);
        check_val("p9_no_vs_err", vs_cnt + perr_cnt, 0);

        // Sync word followed by one pixel
        clear_mon(); pl = '{8'hF0, 8'h5A, 8'hA5, 8'h0F, 8'h11, 8'h22, 8'h33};
        build(MAC_OK, IP_OK, 8'd17, 16'd1234, 7); send(-1, 0); idle(8);
        check_val("sync_vs", vs_cnt, 1);
        check_val("sync_en_count", en_data.size(), 1);
        check_val("sync_pix0", pix(0), 32'h112233);
        check_val("sync_byte_num", 32'(last_num), 7);

        // Four bytes, no sync: trailing partial pixel with done
        clear_mon(); pl = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        build(MAC_OK, IP_OK, 8'd17, 16'd1234, 7); send(-1, 0); idle(8);
        check_val("part_en_count", en_data.size(), 2);
        check_val("part_pix0", pix(0), 32'h0A0B0C);
        check_val("part_pix1", pix(1), 32'h0D0000);
        check_val("part_done_with_en", done_with_en, 1);
        check_val("part_byte_num", 32'(last_num), 4);
        check_val("part_no_vs", vs_cnt, 0);

        // Rejected packets: no strobes of any kind
        set_seq(0, 9);
        clear_mon(); build(48'h00_11_22_33_44_56, IP_OK, 8'd17, 16'd1234, 7); send(-1, 0); idle(8);
        check_val("bad_mac_strobes", strobes(), 0);
        clear_mon(); build(MAC_OK, {8'd192, 8'd168, 8'd1, 8'd11}, 8'd17, 16'd1234, 7); send(-1, 0); idle(8);
        check_val("bad_ip_strobes", strobes(), 0);
        clear_mon(); build(MAC_OK, IP_OK, 8'd6, 16'd1234, 7); send(-1, 0); idle(8);
        check_val("proto6_strobes", strobes(), 0);
        clear_mon(); build(MAC_OK, IP_OK, 8'd17, 16'd1234, 6); send(-1, 0); idle(8);
        check_val("short_preamble_strobes", strobes(), 0);

        // Broadcast destination is accepted
        clear_mon(); pl = '{8'hAA, 8'hBB, 8'hCC};
        build(48'hFF_FF_FF_FF_FF_FF, IP_OK, 8'd17, 16'd1234, 7); send(-1, 0); idle(8);
        check_val("bcast_pix0", pix(0), 32'hAABBCC);
        check_val("bcast_done", done_cnt, 1);

        // Abort after 5 of 9 payload bytes, then a packet after the minimum gap
        clear_mon(); set_seq(0, 9); build(MAC_OK, IP_OK, 8'd17, 16'd1234, 7); send(50 + 5, 0);
        set_seq(8'h10, 3); build(MAC_OK, IP_OK, 8'd17, 16'd1234, 7); send(-1, 0); idle(8);
        check_val("abort_en_count", en_data.size(), 2);
        check_val("abort_pix0", pix(0), 32'h000102);
        check_val("abort_err", perr_cnt, 1);
        check_val("abort_next_pix", pix(1), 32'h101112);
        check_val("abort_done", done_cnt, 1);
        check_val("abort_next_num", 32'(last_num), 3);

        // Back-to-back packets with a one-cycle gap
        clear_mon(); set_seq(1, 6); build(MAC_OK, IP_OK, 8'd17, 16'd1234, 7); send(-1, 0);
        set_seq(7, 6); build(MAC_OK, IP_OK, 8'd17, 16'd1234, 7); send(-1, 0); idle(8);
        check_val("b2b_en_count", en_data.size(), 4);
        check_val("b2b_pix1", pix(1), 32'h040506);
        check_val("b2b_pix3", pix(3), 32'h0A0B0C);
        check_val("b2b_done", done_cnt, 2);

        // UDP destination port filtering
        set_seq(8'h20, 3);
        clear_mon(); build(MAC_OK, IP_OK, 8'd17, 16'd1235, 7); send(-1, 0); idle(8);
`ifdef UDP_PORT_FILTER_EN
        check_val("port1235_done", done_cnt, 0);
        check_val("port1235_strobes", strobes(), 0);
`else
        check_val("port1235_done", done_cnt, 1);
        check_val("port1235_pix0", pix(0), 32'h202122);
`endif
        clear_mon(); build(MAC_OK, IP_OK, 8'd17, 16'd1234, 7); send(-1, 0); idle(8);
        check_val("port1234_done", done_cnt, 1);
        check_val("port1234_pix0", pix(0), 32'h202122);

        // Empty payload (UDP length 8)
        clear_mon(); pl.delete(); build(MAC_OK, IP_OK, 8'd17, 16'd1234, 7); send(-1, 0); idle(8);
        check_val("empty_done", done_cnt, 1);
        check_val("empty_byte_num", 32'(last_num), 0);
        check_val("empty_en_count", en_data.size(), 0);

        // Reset mid-payload, then recovery
        set_seq(0, 9); build(MAC_OK, IP_OK, 8'd17, 16'd1234, 7); send(50 + 7, 1);
        clear_mon(); idle(12);
        check_val("after_rst_strobes", strobes(), 0);
        clear_mon(); send(-1, 0); idle(8);
        check_val("recover_en_count", en_data.size(), 3);
        check_val("recover_pix2", pix(2), 32'h060708);
        check_val("recover_byte_num", 32'(last_num), 9);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
